// File: rtl/mac_pkg.sv
// Shared types for the MAC sequencer: FSM states and the queued operand pair.
package mac_pkg;

  localparam int MAC_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    MCLR   = 3'd2,
    MSTART = 3'd3,
    MWAIT  = 3'd4,
    ACC    = 3'd5,
    DONE   = 3'd6
  } mac_state_t;

  typedef struct packed {
    logic [MAC_DATA_W-1:0] a;
    logic [MAC_DATA_W-1:0] b;
    logic                  last;
  } mac_pair_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// Synchronous operand-pair FIFO; DEPTH must be a power of 2 so pointers wrap naturally.
module mac_operand_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  mac_pair_t                wr_data,
  output mac_pair_t                rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mac_pair_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is cleared too, so the head reads as zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mac_sequencer.sv
// Control stage for mac_datapath: queues operand pairs and sequences load/clear/start/accumulate.
// Optional watchdog on the multiplier wait is enabled with `define MAC_TIMEOUT_EN.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_W      = MAC_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_a,
  input  logic [DATA_W-1:0]             s_b,
  input  logic                          s_last,
  output logic [DATA_W-1:0]             data_inA,
  output logic [DATA_W-1:0]             data_inB,
  output logic                          ldA,
  output logic                          ldB,
  output logic                          rst_for_mul,
  output logic                          start_mul,
  input  logic                          valid_mul,
  output logic                          start_adder,
  output logic                          ldacc,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W-1:0]              term_cnt,
  output logic                          err_timeout,
  output logic [2:0]                    dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_cnt
);

  // Handshake: a pair transfers on any rising edge where s_valid && s_ready; s_ready = FIFO not full.
  // DATA_W must equal MAC_DATA_W, the width carried by mac_pair_t.
  mac_state_t  state_q, state_d;
  mac_pair_t   wr_pair, head;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic        last_q;
  logic        ld_q, clr_q, start_q, acc_q, done_q;
  logic [CNT_W-1:0] term_q;
  logic        wd_expire;

  assign wr_pair = '{a: s_a, b: s_b, last: s_last};
  assign fifo_pop = (state_q == LOAD);

  mac_operand_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s_valid),
    .pop     (fifo_pop),
    .wr_data (wr_pair),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (dbg_fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = LOAD;
      LOAD:    state_d = MCLR;
      MCLR:    state_d = MSTART;
      MSTART:  state_d = MWAIT;
      MWAIT: begin
        if (valid_mul)      state_d = ACC;
        else if (wd_expire) state_d = IDLE;
      end
      ACC:     state_d = last_q ? DONE : IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high exactly while its state is current.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ld_q    <= 1'b0;
      clr_q   <= 1'b0;
      start_q <= 1'b0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      term_q  <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= (state_d == LOAD);
      clr_q   <= (state_d == MCLR);
      start_q <= (state_d == MSTART);
      acc_q   <= (state_d == ACC);
      done_q  <= (state_d == DONE);
      if (state_q == LOAD) last_q <= head.last;
      if (state_q == ACC)       term_q <= term_q + CNT_W'(1);
      else if (state_q == DONE) term_q <= '0;
    end
  end

`ifdef MAC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // Expires on the TIMEOUT_CYC-th consecutive MWAIT cycle without a product.
  assign wd_expire   = (state_q == MWAIT) && !valid_mul && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= (state_q == MWAIT) ? wd_cnt + WD_W'(1) : '0;
      if (wd_expire) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign s_ready     = !fifo_full;
  assign data_inA    = head.a;
  assign data_inB    = head.b;
  assign ldA         = ld_q;
  assign ldB         = ld_q;
  assign rst_for_mul = clr_q;
  assign start_mul   = start_q;
  assign start_adder = acc_q;
  assign ldacc       = acc_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign term_cnt    = term_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural multiplier/accumulator datapath model.
module tb_mac_sequencer;
  import mac_pkg::*;

  localparam int MUL_LAT = 4;

  logic       clk, rst;
  logic       s_valid, s_ready, s_last;
  logic [7:0] s_a, s_b, data_inA, data_inB;
  logic       ldA, ldB, rst_for_mul, start_mul, valid_mul;
  logic       start_adder, ldacc, busy, done, err_timeout;
  logic [7:0] term_cnt;
  logic [2:0] dbg_state, dbg_fifo_cnt;

  mac_sequencer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .s_last(s_last), .data_inA(data_inA), .data_inB(data_inB), .ldA(ldA), .ldB(ldB),
    .rst_for_mul(rst_for_mul), .start_mul(start_mul), .valid_mul(valid_mul),
    .start_adder(start_adder), .ldacc(ldacc), .busy(busy), .done(done), .term_cnt(term_cnt),
    .err_timeout(err_timeout), .dbg_state(dbg_state), .dbg_fifo_cnt(dbg_fifo_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // ---------------- datapath model ----------------
  logic        mul_stall;
  int          mul_cnt;
  logic [7:0]  a_reg, b_reg;
  logic [15:0] prod, sum, out_sum;

  assign valid_mul = (mul_cnt == 1) && !mul_stall;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_cnt <= 0; a_reg <= '0; b_reg <= '0; prod <= '0; sum <= '0; out_sum <= '0;
    end else begin
      if (ldA) a_reg <= data_inA;
      if (ldB) b_reg <= data_inB;
      if (rst_for_mul)    mul_cnt <= 0;
      else if (start_mul) mul_cnt <= MUL_LAT;
      else if (valid_mul) begin mul_cnt <= 0; prod <= a_reg * b_reg; end
      else if (mul_cnt > 1) mul_cnt <= mul_cnt - 1;
      if (ldacc) sum <= sum + prod;
      if (done) begin out_sum <= sum; sum <= '0; end
    end
  end

  // ---------------- monitor ----------------
  int n_ld, n_clr, n_start, n_acc, n_done, cyc;
  int ld_cyc, clr_cyc, start_cyc, acc_cyc, done_cyc, mwait_cyc, err_cyc;
  int term_at_done;
  logic [15:0] got_q[$];
  logic [2:0]  prev_state;
  logic        prev_err;

  initial begin
    n_ld = 0; n_clr = 0; n_start = 0; n_acc = 0; n_done = 0; cyc = 0;
    ld_cyc = 0; clr_cyc = 0; start_cyc = 0; acc_cyc = 0; done_cyc = 0;
    mwait_cyc = 0; err_cyc = 0; term_at_done = 0; prev_state = '0; prev_err = 1'b0;
  end

  always @(negedge clk) begin
    cyc++;
    if (ldA) begin n_ld++; ld_cyc = cyc; got_q.push_back({data_inA, data_inB}); end
    if (rst_for_mul) begin n_clr++; clr_cyc = cyc; end
    if (start_mul) begin n_start++; start_cyc = cyc; end
    if (ldacc) begin n_acc++; acc_cyc = cyc; end
    if (done) begin n_done++; done_cyc = cyc; term_at_done = int'(term_cnt); end
    if (dbg_state == MWAIT && prev_state != MWAIT) mwait_cyc = cyc;
    if (err_timeout && !prev_err) err_cyc = cyc;
    prev_state = dbg_state;
    prev_err   = err_timeout;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp_q[$];
  int got_rd = 0;
  int b_ld, b_acc, b_done;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_ld = n_ld; b_acc = n_acc; b_done = n_done;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input logic l);
    int waited = 0;
    s_a = a; s_b = b; s_last = l; s_valid = 1'b1;
    while (!s_ready && waited < 300) begin step(); waited++; end
    if (!s_ready) check("push_accept", 0, 1);
    else begin
      exp_q.push_back({a, b, l});
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int start = n_done;
    int w = 0;
    while (n_done == start && w < max_cyc) begin step(); w++; end
    check("done_seen", int'(n_done != start), 1);
  endtask

  // Compares the next n loaded pairs against the expected queue, in order.
  task automatic check_pairs(input int n);
    logic [16:0] e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) check("pair_expected", 0, 1);
      else if (got_rd >= got_q.size()) check("pair_loaded", 0, 1);
      else begin
        e = exp_q.pop_front();
        check("pair_ab", int'(got_q[got_rd]), int'(e[16:1]));
        got_rd++;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; mul_stall = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_strobes", int'({ldA, ldB, rst_for_mul, start_mul, start_adder, ldacc, done, busy}), 0);
    check("rst_term_cnt", int'(term_cnt), 0);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_err", int'(err_timeout), 0);
    check("rst_state", int'(dbg_state), 0);
    rst = 1'b1;
    step();

    // Single pair, last=1
    snap();
    push_pair(8'd3, 8'd4, 1'b1);
    wait_done(60);
    repeat (2) step();
    check("single_ld_n", n_ld - b_ld, 1);
    check("single_acc_n", n_acc - b_acc, 1);
    check("single_done_n", n_done - b_done, 1);
    check("single_clr_after_ld", clr_cyc - ld_cyc, 1);
    check("single_start_after_ld", start_cyc - ld_cyc, 2);
    check("single_acc_after_ld", acc_cyc - ld_cyc, 3 + MUL_LAT);
    check("single_done_after_acc", done_cyc - acc_cyc, 1);
    check("single_term_at_done", term_at_done, 1);
    check("single_term_after", int'(term_cnt), 0);
    check("single_sum", int'(out_sum), 12);
    check_pairs(1);

    // Back-to-back dot product of three terms
    snap();
    push_pair(8'd1, 8'd2, 1'b0);
    push_pair(8'd3, 8'd4, 1'b0);
    push_pair(8'd5, 8'd6, 1'b1);
    wait_done(100);
    repeat (3) step();
    check("b2b_acc_n", n_acc - b_acc, 3);
    check("b2b_done_n", n_done - b_done, 1);
    check("b2b_term_at_done", term_at_done, 3);
    check("b2b_term_after", int'(term_cnt), 0);
    check("b2b_sum", int'(out_sum), 44);
    check_pairs(3);

    // Backpressure with multiplier stalled
    snap();
    mul_stall = 1'b1;
    push_pair(8'd1, 8'd1, 1'b0);
    push_pair(8'd2, 8'd3, 1'b0);
    push_pair(8'd4, 8'd5, 1'b0);
    push_pair(8'd6, 8'd7, 1'b0);
    push_pair(8'd8, 8'd9, 1'b0);
    s_a = 8'd10; s_b = 8'd11; s_last = 1'b1; s_valid = 1'b1;
    repeat (10) step();
    check("full_s_ready", int'(s_ready), 0);
    check("full_count", int'(dbg_fifo_cnt), 4);
    check("full_ld_n", n_ld - b_ld, 1);
    mul_stall = 1'b0;
    push_pair(8'd10, 8'd11, 1'b1);
    wait_done(200);
    repeat (3) step();
    check("full_acc_n", n_acc - b_acc, 6);
    check("full_done_n", n_done - b_done, 1);
    check("full_term_at_done", term_at_done, 6);
    check("full_sum", int'(out_sum), 251);
    check_pairs(6);

    // Simultaneous push and pop at occupancy DEPTH-1
    snap();
    mul_stall = 1'b1;
    push_pair(8'd1, 8'd2, 1'b0);
    push_pair(8'd2, 8'd2, 1'b0);
    push_pair(8'd3, 8'd2, 1'b0);
    push_pair(8'd4, 8'd2, 1'b0);
    check("pp_count_before", int'(dbg_fifo_cnt), 3);
    mul_stall = 1'b0;
    begin
      int w = 0;
      while (dbg_state != LOAD && w < 50) begin step(); w++; end
    end
    check("pp_in_load", int'(dbg_state), int'(LOAD));
    check("pp_count_at_load", int'(dbg_fifo_cnt), 3);
    s_a = 8'd5; s_b = 8'd2; s_last = 1'b1; s_valid = 1'b1;
    check("pp_ready_at_load", int'(s_ready), 1);
    exp_q.push_back({8'd5, 8'd2, 1'b1});
    step();
    s_valid = 1'b0;
    check("pp_count_after", int'(dbg_fifo_cnt), 3);
    check("pp_ready_after", int'(s_ready), 1);
    wait_done(200);
    repeat (3) step();
    check("pp_done_n", n_done - b_done, 1);
    check("pp_sum", int'(out_sum), 30);
    check_pairs(5);

    // Reset while waiting on the multiplier with two pairs queued
    mul_stall = 1'b1;
    push_pair(8'd9, 8'd9, 1'b0);
    push_pair(8'd7, 8'd7, 1'b0);
    push_pair(8'd6, 8'd6, 1'b1);
    begin
      int w = 0;
      while (dbg_state != MWAIT && w < 50) begin step(); w++; end
    end
    check("mr_in_mwait", int'(dbg_state), int'(MWAIT));
    check("mr_count", int'(dbg_fifo_cnt), 2);
    snap();
    rst = 1'b0;
    #1;
    check("mr_strobes", int'({ldA, ldB, rst_for_mul, start_mul, start_adder, ldacc, done, busy}), 0);
    check("mr_term_cnt", int'(term_cnt), 0);
    check("mr_count_async", int'(dbg_fifo_cnt), 0);
    check("mr_head", int'({data_inA, data_inB}), 0);
    check_pairs(1);
    exp_q.delete();
    step();
    rst = 1'b1;
    mul_stall = 1'b0;
    repeat (20) step();
    check("mr_busy_after", int'(busy), 0);
    check("mr_count_after", int'(dbg_fifo_cnt), 0);
    check("mr_ld_n", n_ld - b_ld, 0);
    check("mr_done_n", n_done - b_done, 0);

`ifdef MAC_TIMEOUT_EN
    // Watchdog: multiplier never answers
    snap();
    mul_stall = 1'b1;
    push_pair(8'd7, 8'd8, 1'b1);
    begin
      int w = 0;
      while (!err_timeout && w < 200) begin step(); w++; end
    end
    step();
    check("to_err", int'(err_timeout), 1);
    check("to_latency", err_cyc - mwait_cyc, 64);
    check("to_acc_n", n_acc - b_acc, 0);
    check("to_idle", int'(busy), 0);
    check("to_term", int'(term_cnt), 0);
    check_pairs(1);
    mul_stall = 1'b0;
    push_pair(8'd2, 8'd5, 1'b1);
    wait_done(60);
    repeat (2) step();
    check("to_next_sum", int'(out_sum), 10);
    check("to_err_sticky", int'(err_timeout), 1);
    check_pairs(1);
`else
    check("err_tied_low", int'(err_timeout), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
